// File: rtl/vec_sigmoid_pwl_stage.sv
// Elementwise piecewise-linear sigmoid over a tile of signed fixed-point lanes.
// Two-stage elastic pipeline (classify, then evaluate) with a per-vector tile counter.
module vec_sigmoid_pwl_stage #(
  parameter int unsigned TILE_SIZE  = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 8,
  parameter int unsigned D          = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [TILE_SIZE*DATA_WIDTH-1:0]   in_vec,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [TILE_SIZE*DATA_WIDTH-1:0]   out_vec,
  output logic                              out_last,
  output logic [$clog2(D/TILE_SIZE)-1:0]    tile_idx
);

  localparam int unsigned AW      = DATA_WIDTH - 1;
  localparam int unsigned N_TILES = D / TILE_SIZE;
  localparam int unsigned IW      = $clog2(N_TILES);

  localparam logic [IW-1:0]         LAST_TILE = IW'(N_TILES - 1);
  localparam logic [AW-1:0]         MAG_MAX   = {AW{1'b1}};
  localparam logic [AW-1:0]         T_SAT     = AW'(5 << FRAC_BITS);
  localparam logic [AW-1:0]         T_HIGH    = AW'((19 << FRAC_BITS) >> 3);
  localparam logic [AW-1:0]         T_MID     = AW'(1 << FRAC_BITS);
  localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1 << FRAC_BITS);
  localparam logic [DATA_WIDTH-1:0] OFF_HIGH  = DATA_WIDTH'((27 << FRAC_BITS) >> 5);
  localparam logic [DATA_WIDTH-1:0] OFF_MID   = DATA_WIDTH'((5 << FRAC_BITS) >> 3);
  localparam logic [DATA_WIDTH-1:0] OFF_LOW   = DATA_WIDTH'(1 << (FRAC_BITS - 1));

  typedef enum logic [1:0] {SegLow, SegMid, SegHigh, SegSat} seg_e;

  logic                              s1_valid_q, s2_valid_q;
  logic [TILE_SIZE-1:0][AW-1:0]      s1_mag_q, mag_d;
  seg_e [TILE_SIZE-1:0]              s1_seg_q, seg_d;
  logic [TILE_SIZE-1:0]              s1_neg_q, neg_d;
  logic [TILE_SIZE*DATA_WIDTH-1:0]   out_vec_q, res_d;
  logic [IW-1:0]                     tile_q;
  logic                              s1_move, s1_load, in_fire, out_fire;

  assign s1_move  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s1_move;
  assign in_ready = !rst && !clr && s1_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  assign out_valid = s2_valid_q;
  assign out_vec   = out_vec_q;
  assign tile_idx  = tile_q;
  assign out_last  = s2_valid_q && (tile_q == LAST_TILE);

  for (genvar l = 0; l < TILE_SIZE; l++) begin : g_lane
    logic [DATA_WIDTH-1:0] x, x_neg, y;

    assign x        = in_vec[l*DATA_WIDTH +: DATA_WIDTH];
    assign x_neg    = -x;
    assign neg_d[l] = x[DATA_WIDTH-1];
    // Negating the most negative value wraps back to negative; clamp it instead.
    assign mag_d[l] = !neg_d[l] ? x[AW-1:0] :
                      (x_neg[DATA_WIDTH-1] ? MAG_MAX : x_neg[AW-1:0]);
    assign seg_d[l] = (mag_d[l] >= T_SAT)  ? SegSat  :
                      (mag_d[l] >= T_HIGH) ? SegHigh :
                      (mag_d[l] >= T_MID)  ? SegMid  : SegLow;

    always_comb begin
      unique case (s1_seg_q[l])
        SegSat:  y = ONE;
        SegHigh: y = DATA_WIDTH'(s1_mag_q[l] >> 5) + OFF_HIGH;
        SegMid:  y = DATA_WIDTH'(s1_mag_q[l] >> 3) + OFF_MID;
        default: y = DATA_WIDTH'(s1_mag_q[l] >> 2) + OFF_LOW;
      endcase
    end

    // Sigmoid symmetry: s(-a) = 1 - s(a).
    assign res_d[l*DATA_WIDTH +: DATA_WIDTH] = s1_neg_q[l] ? ONE - y : y;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_mag_q   <= '0;
      s1_seg_q   <= {TILE_SIZE{SegLow}};
      s1_neg_q   <= '0;
      out_vec_q  <= '0;
      tile_q     <= '0;
    end else if (clr) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      tile_q     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid_q <= in_valid;
      end
      if (in_fire) begin
        s1_mag_q <= mag_d;
        s1_seg_q <= seg_d;
        s1_neg_q <= neg_d;
      end
      if (s1_move) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s1_move && s1_valid_q) begin
        out_vec_q <= res_d;
      end
      if (out_fire) begin
        tile_q <= (tile_q == LAST_TILE) ? '0 : tile_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vec_sigmoid_pwl_stage.sv
// Self-checking bench for vec_sigmoid_pwl_stage: directed segment points plus
// scoreboarded streaming, back-pressure, clr flush and async reset scenarios.
module tb_vec_sigmoid_pwl_stage;

  localparam int TS = 4;
  localparam int DW = 16;
  localparam int FB = 8;
  localparam int DD = 256;
  localparam int NT = DD / TS;
  localparam int IW = $clog2(NT);

  logic             clk = 1'b0;
  logic             rst, clr, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [TS*DW-1:0] in_vec, out_vec;
  logic [IW-1:0]    tile_idx;

  vec_sigmoid_pwl_stage #(
    .TILE_SIZE  (TS),
    .DATA_WIDTH (DW),
    .FRAC_BITS  (FB),
    .D          (DD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_vec    (in_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_last  (out_last),
    .tile_idx  (tile_idx)
  );

  always #5 clk = ~clk;

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [TS*DW-1:0] sb_q[$];
  int               exp_tile = 0;
  int               out_cnt  = 0;
  bit               in_acc, out_acc, stall_q;
  logic [TS*DW-1:0] hold_vec;
  logic [IW-1:0]    hold_idx;
  logic             hold_last;
  // Snapshot of DUT outputs taken at the falling edge inside tick().
  logic             s_valid, s_last, s_in_ready;
  logic [TS*DW-1:0] s_vec;
  logic [IW-1:0]    s_idx;

  int bnd[16] = '{0, 255, 256, 607, 608, 1279, 1280, -1, -255, -256, -608, -1280,
                  32767, -32768, -32767, 100};

  function automatic logic [DW-1:0] ref_sig(input logic signed [DW-1:0] x);
    int a, y;
    a = int'(x);
    if (a < 0) a = -a;
    if (a > 32767) a = 32767;
    if (a >= 1280)     y = 256;
    else if (a >= 608) y = a / 32 + 216;
    else if (a >= 256) y = a / 8 + 160;
    else               y = a / 4 + 128;
    if (x < 0) y = 256 - y;
    return DW'(y);
  endfunction

  function automatic logic [TS*DW-1:0] ref_vec(input logic [TS*DW-1:0] v);
    logic [TS*DW-1:0] r;
    for (int l = 0; l < TS; l++) r[l*DW +: DW] = ref_sig(v[l*DW +: DW]);
    return r;
  endfunction

  function automatic logic [TS*DW-1:0] pack4(input int a, input int b, input int c,
                                             input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  function automatic logic [TS*DW-1:0] rand_vec();
    logic [TS*DW-1:0] v;
    for (int l = 0; l < TS; l++) begin
      case ($urandom_range(0, 2))
        0:       v[l*DW +: DW] = DW'($urandom);
        1:       v[l*DW +: DW] = DW'($urandom_range(0, 2800)) - DW'(1400);
        default: v[l*DW +: DW] = DW'(bnd[$urandom_range(0, 15)]);
      endcase
    end
    return v;
  endfunction

  // One clock cycle: sample at the falling edge, run the scoreboard, return 1 after the rise.
  task automatic tick();
    logic [TS*DW-1:0] e;
    @(negedge clk);
    s_valid    = out_valid;
    s_vec      = out_vec;
    s_idx      = tile_idx;
    s_last     = out_last;
    s_in_ready = in_ready;
    in_acc     = in_valid && in_ready;
    out_acc    = out_valid && out_ready;
    if (rst || clr) begin
      sb_q.delete();
      exp_tile = 0;
      stall_q  = 1'b0;
    end else begin
      if (stall_q) begin
        n_tests++;
        if (out_valid !== 1'b1 || out_vec !== hold_vec || tile_idx !== hold_idx ||
            out_last !== hold_last) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b vec=%h idx=%0d last=%b, need v=1 vec=%h idx=%0d last=%b",
                   out_valid, out_vec, tile_idx, out_last, hold_vec, hold_idx, hold_last);
        end
      end
      if (in_acc) sb_q.push_back(ref_vec(in_vec));
      if (out_acc) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: unexpected output vec=%h", out_vec);
        end else begin
          e = sb_q.pop_front();
          if (out_vec !== e || tile_idx !== IW'(exp_tile) ||
              out_last !== (exp_tile == NT - 1)) begin
            n_fail++;
            $display("FAIL sb_data: got vec=%h idx=%0d last=%b, need vec=%h idx=%0d last=%b",
                     out_vec, tile_idx, out_last, e, exp_tile, exp_tile == NT - 1);
          end
        end
        exp_tile = (exp_tile + 1) % NT;
        out_cnt++;
      end
      stall_q   = out_valid && !out_ready;
      hold_vec  = out_vec;
      hold_idx  = tile_idx;
      hold_last = out_last;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream(input int n, input int in_pct, input int out_pct);
    int sent, g, start;
    sent = 0; g = 0; start = out_cnt;
    in_acc = 1'b0; in_valid = 1'b0;
    while (sent < n) begin
      if (g >= 30 * n + 100) begin
        n_tests++; n_fail++;
        $display("FAIL stream_timeout: sent %0d of %0d beats", sent, n);
        break;
      end
      if (!in_valid || in_acc) begin
        in_valid = ($urandom_range(0, 99) < in_pct);
        in_vec   = rand_vec();
      end
      out_ready = ($urandom_range(0, 99) < out_pct);
      tick();
      g++;
      if (in_acc) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1; g = 0;
    while (sb_q.size() != 0 && g < 20) begin
      tick();
      g++;
    end
    n_tests++;
    if (out_cnt - start != sent) begin
      n_fail++;
      $display("FAIL stream_count: got %0d outputs, need %0d", out_cnt - start, sent);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (s_valid !== 1'b0 || s_in_ready !== 1'b0 || s_idx !== '0 || s_last !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: got v=%b rdy=%b idx=%0d last=%b, need 0 0 0 0",
                 s_valid, s_in_ready, s_idx, s_last);
      end
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (s_in_ready !== 1'b1 || s_valid !== 1'b0 || s_idx !== '0 || s_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b v=%b idx=%0d vec=%h, need 1 0 0 0",
               s_in_ready, s_valid, s_idx, s_vec);
    end
  endtask

  task automatic test_segments();
    logic [TS*DW-1:0] e1, e2;
    e1 = pack4(128, 192, 64, 256);
    e2 = pack4(235, 235, 153, 0);
    out_ready = 1'b1;
    in_valid  = 1'b1; in_vec = pack4(0, 256, -256, 1280);
    tick();
    n_tests++;
    if (!in_acc) begin n_fail++; $display("FAIL seg_accept: got in_ready=0, need 1"); end
    in_vec = pack4(608, 607, 100, -32768);
    tick();
    n_tests++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL seg_latency: got out_valid=%b one cycle in, need 0", s_valid);
    end
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (s_valid !== 1'b1 || s_vec !== e1) begin
      n_fail++; $display("FAIL seg_beat1: got v=%b vec=%h, need v=1 vec=%h", s_valid, s_vec, e1);
    end
    tick();
    n_tests++;
    if (s_valid !== 1'b1 || s_vec !== e2) begin
      n_fail++; $display("FAIL seg_beat2: got v=%b vec=%h, need v=1 vec=%h", s_valid, s_vec, e2);
    end
    tick();
  endtask

  task automatic test_streaming();
    int n_in, n_out;
    n_in = 0; n_out = 0;
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 134; c++) begin
      in_valid = (c < 130);
      in_vec   = rand_vec();
      tick();
      if (in_acc) n_in++;
      if (out_acc) begin
        if (n_out == 63 || n_out == 127) begin
          n_tests++;
          if (s_last !== 1'b1) begin
            n_fail++; $display("FAIL stream_last: beat %0d got out_last=%b, need 1", n_out, s_last);
          end
        end
        if (n_out == 64 || n_out == 129) begin
          n_tests++;
          if (s_idx !== IW'(n_out % NT)) begin
            n_fail++;
            $display("FAIL stream_tile: beat %0d got tile_idx=%0d, need %0d", n_out, s_idx, n_out % NT);
          end
        end
        n_out++;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (n_in != 130 || n_out != 130) begin
      n_fail++;
      $display("FAIL stream_throughput: got %0d in / %0d out, need 130 / 130", n_in, n_out);
    end
  endtask

  task automatic test_back_pressure();
    run_stream(1000, 70, 50);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL bp_drain: got %0d beats pending, need 0", sb_q.size());
    end
  endtask

  task automatic test_clr();
    int start, g;
    bit seen;
    clr = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    clr = 1'b0; start = out_cnt; g = 0;
    while (out_cnt - start < 10 && g < 60) begin
      in_valid = 1'b1; in_vec = rand_vec();
      tick();
      g++;
    end
    n_tests++;
    if (out_cnt - start != 10) begin
      n_fail++; $display("FAIL clr_prefill: got %0d outputs, need 10", out_cnt - start);
    end
    clr = 1'b1; in_vec = rand_vec();
    tick();
    n_tests++;
    if (s_in_ready !== 1'b0) begin
      n_fail++; $display("FAIL clr_in_ready: got %b during clr, need 0", s_in_ready);
    end
    clr = 1'b0; in_valid = 1'b0;
    tick();
    n_tests++;
    if (s_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_flush: got out_valid=%b after clr, need 0", s_valid);
    end
    seen = 1'b0; g = 0; start = out_cnt;
    while (out_cnt - start < 3 && g < 30) begin
      in_valid = (g < 3); in_vec = rand_vec();
      tick();
      if (out_acc && !seen) begin
        seen = 1'b1;
        n_tests++;
        if (s_idx !== '0) begin
          n_fail++; $display("FAIL clr_tile0: got tile_idx=%0d, need 0", s_idx);
        end
      end
      g++;
    end
    in_valid = 1'b0;
    n_tests++;
    if (out_cnt - start != 3) begin
      n_fail++; $display("FAIL clr_post_count: got %0d outputs, need 3", out_cnt - start);
    end
  endtask

  task automatic test_async_reset();
    int start;
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_vec = rand_vec();
      tick();
    end
    n_tests++;
    if (s_in_ready !== 1'b0 || s_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_stall: got in_ready=%b out_valid=%b, need 0 1", s_in_ready, s_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got out_valid=%b in_ready=%b mid-cycle, need 0 0",
               out_valid, in_ready);
    end
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    start = out_cnt;
    run_stream(20, 100, 100);
    n_tests++;
    if (out_cnt - start != 20) begin
      n_fail++; $display("FAIL rst_restart: got %0d outputs, need 20", out_cnt - start);
    end
  endtask

  initial begin
    test_reset();
    test_segments();
    test_streaming();
    test_back_pressure();
    test_clr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
